// File: rtl/data_convert_pkg.sv
// Shared defaults and width helpers for the half-word packing converter.
package data_convert_pkg;

    localparam int DEF_HALF_W    = 4;
    localparam int DEF_OUT_UNITS = 2;

    // Width needed to count 0..units inclusive.
    function automatic int cnt_w(input int units);
        return $clog2(units + 1);
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output holding register: keeps a packed word and its unit count stable until consumed.
module pack_out_reg #(
    parameter int OUT_W = 8,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [OUT_W-1:0] data_i,
    input  logic [CNT_W-1:0] units_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [OUT_W-1:0] data_o,
    output logic [CNT_W-1:0] units_o
);

    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] units_q, units_d;

    // The packer only asserts load_i when the slot is free, so load wins over drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        units_d = units_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            units_d = units_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            units_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            units_q <= units_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign units_o = units_q;

endmodule

// File: rtl/data_pack_convert.sv
// Packs half or full input words into OUT_UNITS-unit output words, first unit in the MSBs.
module data_pack_convert
    import data_convert_pkg::*;
#(
    parameter int HALF_W    = DEF_HALF_W,
    parameter int OUT_UNITS = DEF_OUT_UNITS,
    localparam int IN_W     = 2 * HALF_W,
    localparam int OUT_W    = OUT_UNITS * HALF_W,
    localparam int CNT_W    = cnt_w(OUT_UNITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_full,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_units
);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic              slot_free;
    logic              accept;
    logic              load;
    logic [OUT_W-1:0]  ld_data;
    logic [CNT_W-1:0]  ld_units;
    logic [OUT_W-1:0]  merged;
    logic [HALF_W-1:0] hi_unit, lo_unit;
    int                cnt_i;

    // Unused accumulator slots are always zero, so OR-ing a unit in is safe.
    function automatic logic [OUT_W-1:0] place(input logic [OUT_W-1:0] acc, input int idx,
                                               input logic [HALF_W-1:0] unit);
        logic [OUT_W-1:0] ext;
        ext = '0;
        ext[OUT_W-1 -: HALF_W] = unit;
        return acc | (ext >> (idx * HALF_W));
    endfunction

    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = reset_n & enable & ~flush & slot_free;
    assign accept    = in_valid & in_ready;
    assign hi_unit   = in_data[IN_W-1:HALF_W];
    assign lo_unit   = in_data[HALF_W-1:0];
    assign cnt_i     = int'(count_q);

    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        load     = 1'b0;
        ld_data  = '0;
        ld_units = '0;
        merged   = '0;
        if (!enable) begin
            acc_d   = '0;
            count_d = '0;
        end else if (flush) begin
            if (count_q != '0 && slot_free) begin
                load     = 1'b1;
                ld_data  = acc_q;
                ld_units = count_q;
                acc_d    = '0;
                count_d  = '0;
            end
        end else if (accept) begin
            if (in_full) begin
                merged = place(acc_q, cnt_i, hi_unit);
                if (cnt_i + 2 < OUT_UNITS) begin
                    acc_d   = place(merged, cnt_i + 1, lo_unit);
                    count_d = CNT_W'(cnt_i + 2);
                end else if (cnt_i + 2 == OUT_UNITS) begin
                    load     = 1'b1;
                    ld_data  = place(merged, cnt_i + 1, lo_unit);
                    ld_units = CNT_W'(OUT_UNITS);
                    acc_d    = '0;
                    count_d  = '0;
                end else begin
                    // Low half spills over and starts the next word.
                    load     = 1'b1;
                    ld_data  = merged;
                    ld_units = CNT_W'(OUT_UNITS);
                    acc_d    = place('0, 0, lo_unit);
                    count_d  = CNT_W'(1);
                end
            end else begin
                merged = place(acc_q, cnt_i, lo_unit);
                if (cnt_i + 1 == OUT_UNITS) begin
                    load     = 1'b1;
                    ld_data  = merged;
                    ld_units = CNT_W'(OUT_UNITS);
                    acc_d    = '0;
                    count_d  = '0;
                end else begin
                    acc_d   = merged;
                    count_d = CNT_W'(cnt_i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    pack_out_reg #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (load),
        .data_i  (ld_data),
        .units_i (ld_units),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .units_o (out_units)
    );

endmodule

// File: tb/tb_data_pack_convert.sv
// Directed table-driven bench for data_pack_convert with 2-unit and 4-unit instances.
module tb_data_pack_convert;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_full = 1'b0;
    logic [7:0]  in_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir2, ov2;
    logic [7:0]  od2;
    logic [1:0]  ou2;
    logic        ir4, ov4;
    logic [15:0] od4;
    logic [2:0]  ou4;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    data_pack_convert #(.HALF_W(4), .OUT_UNITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .in_ready(ir2),
        .in_full(in_full), .in_data(in_data), .flush(flush), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2), .out_units(ou2)
    );

    data_pack_convert #(.HALF_W(4), .OUT_UNITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .in_ready(ir4),
        .in_full(in_full), .in_data(in_data), .flush(flush), .out_valid(ov4),
        .out_ready(out_ready), .out_data(od4), .out_units(ou4)
    );

    typedef struct {
        bit          sel;    // 0: 2-unit instance, 1: 4-unit instance
        bit          rst;
        bit          en;
        bit          iv;
        bit          full;
        logic [7:0]  data;
        bit          fl;
        bit          ordy;
        bit          exp_ir;
        bit          exp_ov;
        logic [15:0] exp_od;
        logic [2:0]  exp_ou;
        bit          chk_d;  // check data/units even when out_valid is expected low
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit sel, bit rst, bit en, bit iv, bit full, logic [7:0] data,
                               bit fl, bit ordy, bit exp_ir, bit exp_ov,
                               logic [15:0] exp_od, logic [2:0] exp_ou, bit chk_d);
        vec_t v;
        v.sel = sel; v.rst = rst; v.en = en; v.iv = iv; v.full = full; v.data = data;
        v.fl = fl; v.ordy = ordy; v.exp_ir = exp_ir; v.exp_ov = exp_ov;
        v.exp_od = exp_od; v.exp_ou = exp_ou; v.chk_d = chk_d;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s vec %0d: got 0x%0h want 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] od;
        logic [2:0]  ou;
        @(negedge clk);
        reset_n   = ~v.rst;
        enable    = v.en;
        in_valid  = v.iv;
        in_full   = v.full;
        in_data   = v.data;
        flush     = v.fl;
        out_ready = v.ordy;
        #1;
        check("in_ready", idx, {15'd0, (v.sel ? ir4 : ir2)}, {15'd0, v.exp_ir});
        @(posedge clk);
        #1;
        od = v.sel ? od4 : {8'd0, od2};
        ou = v.sel ? ou4 : {1'b0, ou2};
        check("out_valid", idx, {15'd0, (v.sel ? ov4 : ov2)}, {15'd0, v.exp_ov});
        if (v.exp_ov || v.chk_d) begin
            check("out_data", idx, od, v.exp_od);
            check("out_units", idx, {13'd0, ou}, {13'd0, v.exp_ou});
        end
    endtask

    initial begin
        //            sel rst en iv fu data  fl or  ir ov  od        ou chk
        tbl.push_back(V(0, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0, 16'h0000, 0, 1));
        // basic packing with spill-over
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h84, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 8'h21, 0, 1, 1, 1, 16'h0042, 2, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 8'h69, 0, 1, 1, 1, 16'h0016, 2, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 8'hA5, 0, 1, 1, 1, 16'h0095, 2, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000, 0, 0));
        // backpressure hold then drain with back-to-back load
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h84, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 8'h21, 0, 0, 1, 1, 16'h0042, 2, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 8'h69, 0, 0, 0, 1, 16'h0042, 2, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 8'h69, 0, 1, 1, 1, 16'h0016, 2, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0090, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        // flush of a partial word, then flush with nothing held
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h07, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h00, 1, 1, 0, 1, 16'h0070, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        // enable low discards the held unit
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h03, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 0, 1, 0, 8'h0F, 0, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h05, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h06, 0, 1, 1, 1, 16'h0056, 2, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        // flush waits while the output slot is busy
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h01, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 8'h23, 0, 0, 1, 1, 16'h0012, 2, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 1, 16'h0012, 2, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0030, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        // pending output survives enable low
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h0C, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 8'h0D, 0, 0, 1, 1, 16'h00CD, 2, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 16'h00CD, 2, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));
        // 4-unit instance: carry into the next word and final flush
        tbl.push_back(V(1, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(V(1, 0, 1, 1, 1, 8'h12, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(1, 0, 1, 1, 1, 8'h34, 0, 1, 1, 1, 16'h1234, 4, 0));
        tbl.push_back(V(1, 0, 1, 1, 1, 8'h56, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(1, 0, 1, 1, 0, 8'h07, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(V(1, 0, 1, 1, 1, 8'h89, 0, 1, 1, 1, 16'h5678, 4, 0));
        tbl.push_back(V(1, 0, 1, 0, 0, 8'h00, 1, 1, 0, 1, 16'h9000, 1, 0));
        tbl.push_back(V(1, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Reset while a word is pending and one unit is held.
        apply(V(0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 16'h0000, 0, 1), 100);
        apply(V(0, 0, 1, 1, 0, 8'h01, 0, 1, 1, 0, 16'h0000, 0, 0), 101);
        apply(V(0, 0, 1, 1, 1, 8'h23, 0, 0, 1, 1, 16'h0012, 2, 0), 102);
        apply(V(0, 1, 1, 1, 0, 8'h0E, 0, 0, 0, 0, 16'h0000, 0, 1), 103);
        apply(V(0, 0, 1, 1, 0, 8'h0A, 0, 1, 1, 0, 16'h0000, 0, 0), 104);
        apply(V(0, 0, 1, 1, 0, 8'h0B, 0, 1, 1, 1, 16'h00AB, 2, 0), 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/data_pack_convert.md
DATA_PACK_CONVERT -- requirements
Module: data_pack_convert

Interface
REQ-001 SHALL have parameter HALF_W, default 4; width of one packing unit (half input word).
REQ-002 SHALL have parameter OUT_UNITS, default 2; units per output word, legal range 2..16; IN_W = 2*HALF_W, OUT_W = OUT_UNITS*HALF_W, CNT_W = clog2(OUT_UNITS+1).
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  in  1  0 = block idle; accumulator cleared.
REQ-006 SHALL have port in_valid  in  1  input word offered.
REQ-007 SHALL have port in_ready  out  1  input word accepted when in_valid & in_ready.
REQ-008 SHALL have port in_full  in  1  1 = all IN_W bits valid (two units, high half first); 0 = low HALF_W bits only (one unit).
REQ-009 SHALL have port in_data  in  IN_W  input data.
REQ-010 SHALL have port flush  in  1  emit the partial word held in the accumulator.
REQ-011 SHALL have port out_valid  out  1  output word present.
REQ-012 SHALL have port out_ready  in  1  output consumed when out_valid & out_ready.
REQ-013 SHALL have port out_data  out  OUT_W  packed word, first-received unit in MSBs.
REQ-014 SHALL have port out_units  out  CNT_W  valid units in out_data, MSB-aligned; OUT_UNITS for full words.

Function
REQ-015 Accumulator SHALL hold count units (0..OUT_UNITS-1), appended MSB-first in arrival order; count is the sole packing state.
REQ-016 in_ready SHALL equal enable & ~flush & (~out_valid | out_ready).
REQ-017 Accepted half input SHALL append one unit; accepted full input SHALL append in_data[IN_W-1:HALF_W] then in_data[HALF_W-1:0].
REQ-018 When count plus appended units reaches OUT_UNITS, the completed word SHALL be loaded into the output register the same edge (out_valid high next cycle, latency 1), with out_units = OUT_UNITS; any remaining unit (max one) SHALL become the new accumulator content with count = 1.
REQ-019 When count plus appended units is below OUT_UNITS, no output SHALL be produced and count SHALL advance.
REQ-020 out_valid, out_data and out_units SHALL hold stable while out_valid & ~out_ready.
REQ-021 out_valid SHALL fall on the edge where out_ready is high, unless a new word loads the same edge (back-to-back, one word per cycle).
REQ-022 flush with enable high, count > 0 and output slot free (~out_valid | out_ready) SHALL load the accumulator into the output register zero-padded in the LSBs, out_units = count, and clear count; input is not accepted that cycle.
REQ-023 flush with count = 0 SHALL produce no output; flush with slot busy SHALL wait (level-sensitive) until the slot frees.
REQ-024 enable low SHALL clear count and accumulator next edge; a pending out_valid word SHALL remain until consumed.
REQ-025 Unaccepted in_data and in_full SHALL have no effect.

Reset
REQ-026 reset_n low at an edge SHALL force out_valid = 0, out_data = 0, out_units = 0, count = 0, accumulator = 0, overriding all other inputs, including mid-word and while out_valid is high.
REQ-027 in_ready SHALL be 0 during reset.

Structure
REQ-028 Package data_convert_pkg SHALL hold default HALF_W/OUT_UNITS constants and the CNT_W width function.
REQ-029 The output register with valid/ready hold SHALL be a sub-module pack_out_reg (OUT_W + CNT_W payload); packing logic remains in data_pack_convert.

Verification (HALF_W=4, OUT_UNITS=2 unless stated)
REQ-030 Half 0x84, full 0x21, full 0x69, half 0xA5, out_ready=1 -> outputs 0x42, 0x16, 0x95, each out_units=2; count 0 at end.
REQ-031 out_ready=0 after word 0x42 -> out_valid, 0x42 held, in_ready=0; out_ready=1 -> drained in one cycle, next word follows.
REQ-032 Half 0x07 then flush -> out_data 0x70, out_units=1; second flush with count 0 -> no out_valid.
REQ-033 Half 0x03, enable=0 one cycle, then half 0x05, half 0x06 -> single output 0x56 (0x3 discarded).
REQ-034 OUT_UNITS=4: full 0x12, full 0x34, full 0x56, half 0x07, full 0x89 -> 0x1234, then 0x5678 with carry 9; flush -> 0x9000, out_units=1.
REQ-035 reset_n low for one edge while out_valid=1 and count=1 -> all outputs 0 next cycle; subsequent half 0x0A, half 0x0B -> 0xAB.
